pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge system clock.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: start  input  1  request to scan data_in; sampled only in IDLE.
REQ-004 SHALL have ports: data_in  input  8  word to scan, MSB first.
REQ-005 SHALL have ports: pat_we  input  1  pattern write enable; honoured only in IDLE.
REQ-006 SHALL have ports: pat_in  input  4  new pattern; pat_in[3] is the oldest bit of the window.
REQ-007 SHALL have ports: busy  output  1  high while a word is being shifted.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse at end of scan.
REQ-009 SHALL have ports: match_pulse  output  1  one-cycle pulse per detected occurrence.
REQ-010 SHALL have ports: match_cnt  output  4  occurrences found in the last or current word.
REQ-011 SHALL have ports: serial_bit  output  1  bit most recently presented to the detector.
REQ-012 SHALL have no parameters; pattern length fixed at 4, word length fixed at 8.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE, all outputs registered.
REQ-014 In IDLE, start=1 at edge E SHALL latch data_in, clear match_cnt and window history, set bit index 7, and enter SHIFT.
REQ-015 In SHIFT, the edges E+1..E+8 SHALL each present one bit (data_in[7] first) to the detector and drive it on serial_bit.
REQ-016 The detector SHALL be a Mealy matcher with window {prev3, prev2, prev1, current} compared to the stored pattern.
REQ-017 A match SHALL be counted only when at least 4 bits of the current word have been presented; history never spans words.
REQ-018 Overlapping occurrences SHALL each count, e.g. 1001001 holds two 1001 matches.
REQ-019 On a match at edge k, match_pulse SHALL be 1 for the cycle after k, and match_cnt SHALL increment at k.
REQ-020 match_cnt SHALL not wrap: the maximum per word is 5, which fits 4 bits.
REQ-021 At edge E+8, state SHALL go to DONE, busy SHALL go to 0 and done SHALL go to 1 for exactly one cycle; then IDLE.
REQ-022 busy SHALL be 1 from edge E through edge E+8, exclusive of the DONE cycle.
REQ-023 start SHALL be ignored in SHIFT and DONE; no queueing.
REQ-024 pat_we SHALL update the stored pattern at the edge only when state is IDLE and start=0; otherwise the write is dropped.
REQ-025 If pat_we and start are both 1 in IDLE, start SHALL win and the pattern SHALL remain unchanged.
REQ-026 match_cnt SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, busy=0, done=0, match_pulse=0, match_cnt=0, serial_bit=0, history cleared, and pattern=4'b1001.
REQ-028 Reset asserted mid-scan SHALL abort the scan with no done pulse; operation SHALL resume at the first edge after reset returns to 1.

Verification
REQ-029 The bench SHALL cover reset then idle: reset=0 then reset=1 -> busy=0, done=0, match_cnt=0, pattern 1001.
REQ-030 The bench SHALL cover a default-pattern scan: start with data_in=8'b10010010 -> two match_pulses after the 4th and 7th bit edges, match_cnt=2, done one cycle after edge E+8.
REQ-031 The bench SHALL cover a reprogrammed pattern: pat_we with pat_in=4'b0000, then data_in=8'h00 -> match_cnt=5, five consecutive match_pulses.
REQ-032 The bench SHALL cover no cross-word match: first word 8'b00000100, then word 8'b10000000 with pattern 1001 -> match_cnt=0 for both.
REQ-033 The bench SHALL cover writes and starts while busy: pat_we=1 and start=1 during SHIFT -> pattern unchanged, the scan completes normally, and no second scan starts.
REQ-034 The bench SHALL cover reset mid-scan: reset=0 at edge E+3 -> busy=0, match_cnt=0, no done pulse, pattern restored to 1001.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serialises an 8-bit word MSB first and counts
// occurrences of a programmable 4-bit pattern in that word, overlapping
// occurrences included. Matches never span two words.
module pattern_scan_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       pat_we,
  input  logic [3:0] pat_in,
  output logic       busy,
  output logic       done,
  output logic       match_pulse,
  output logic [3:0] match_cnt,
  output logic       serial_bit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_RESET = 4'b1001;

  state_t     state, state_nx;
  logic [7:0] word, word_nx;
  logic [2:0] idx, idx_nx;
  logic [2:0] hist, hist_nx;     // {prev3, prev2, prev1}
  logic [3:0] pat, pat_nx;
  logic       busy_nx, done_nx, pulse_nx, sbit_nx;
  logic [3:0] cnt_nx;
  logic       cur_bit;

  // Window compare: oldest bit of the window lines up with pattern bit 3.
  // Only windows made entirely of bits from the current word are eligible,
  // which holds once index has dropped to 4 (bits 7..4 already presented).
  function automatic logic win_match(input logic [2:0] h, input logic b,
                                     input logic [3:0] p, input logic [2:0] i);
    win_match = (i <= 3'd4) && ({h, b} == p);
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx = state;
    word_nx  = word;
    idx_nx   = idx;
    hist_nx  = hist;
    pat_nx   = pat;
    busy_nx  = busy;
    done_nx  = 1'b0;
    pulse_nx = 1'b0;
    cnt_nx   = match_cnt;
    sbit_nx  = serial_bit;
    cur_bit  = word[idx];
    case (state)
      IDLE: begin
        if (start) begin
          // start takes priority over a simultaneous pattern write
          word_nx  = data_in;
          cnt_nx   = 4'd0;
          hist_nx  = 3'd0;
          idx_nx   = 3'd7;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end else if (pat_we) begin
          pat_nx = pat_in;
        end
      end
      SHIFT: begin
        sbit_nx = cur_bit;
        hist_nx = {hist[1:0], cur_bit};
        if (win_match(hist, cur_bit, pat, idx)) begin
          pulse_nx = 1'b1;
          cnt_nx   = match_cnt + 4'd1;
        end
        if (idx == 3'd0) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          idx_nx = idx - 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any scan and restores the default pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word        <= 8'd0;
      idx         <= 3'd0;
      hist        <= 3'd0;
      pat         <= PAT_RESET;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_pulse <= 1'b0;
      match_cnt   <= 4'd0;
      serial_bit  <= 1'b0;
    end else begin
      state       <= state_nx;
      word        <= word_nx;
      idx         <= idx_nx;
      hist        <= hist_nx;
      pat         <= pat_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      match_pulse <= pulse_nx;
      match_cnt   <= cnt_nx;
      serial_bit  <= sbit_nx;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: the stimulus process pushes the
// expected outcome of every accepted scan; the monitor rebuilds what the DUT
// actually produced and compares when done is presented.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       pat_we = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic       busy, done, match_pulse, serial_bit;
  logic [3:0] match_cnt;

  pattern_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .pat_we(pat_we), .pat_in(pat_in), .busy(busy), .done(done),
    .match_pulse(match_pulse), .match_cnt(match_cnt), .serial_bit(serial_bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    int         cnt;
    logic [7:0] mask;   // bit k-1 set when the k-th presented bit completes a match
  } exp_t;

  exp_t       q[$];
  logic [3:0] model_pat = 4'b1001;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the window ending at the k-th presented bit is word bits
  // [11-k : 8-k]; eligible once k >= 4.
  function automatic exp_t model(input logic [7:0] w, input logic [3:0] p);
    exp_t e;
    logic [7:0] s;
    e.word = w;
    e.cnt  = 0;
    e.mask = 8'd0;
    for (int k = 4; k <= 8; k++) begin
      s = w >> (8 - k);
      if (s[3:0] == p) begin
        e.cnt++;
        e.mask[k-1] = 1'b1;
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int         ofs = -1;
  logic       busy_q = 1'b0;
  logic [7:0] obs_mask, obs_word;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      ofs    = -1;
      busy_q = 1'b0;
    end else begin
      if (ofs >= 0) ofs++;
      if (busy && !busy_q && ofs < 0) begin
        ofs      = 0;
        obs_mask = 8'd0;
        obs_word = 8'd0;
      end
      if (ofs >= 1 && ofs <= 8) begin
        obs_word = {obs_word[6:0], serial_bit};
        if (match_pulse) obs_mask[ofs-1] = 1'b1;
      end else if (match_pulse) begin
        chk("stray_match_pulse", 1, 0);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_offset", ofs, 8);
          chk("busy_at_done", busy, 0);
          chk("match_cnt", match_cnt, e.cnt);
          chk("match_mask", obs_mask, e.mask);
          chk("serial_word", obs_word, e.word);
        end
        ofs = -1;
      end else if (ofs > 12) begin
        chk("scan_timeout", ofs, 8);
        ofs = -1;
      end
      busy_q = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic write_pat(input logic [3:0] p);
    @(negedge clk);
    pat_we = 1'b1;
    pat_in = p;
    @(negedge clk);
    pat_we = 1'b0;
    model_pat = p;
  endtask

  task automatic scan(input logic [7:0] w, input bit junk, input bit we_too,
                      input logic [3:0] pin);
    exp_t e;
    @(negedge clk);
    e = model(w, model_pat);
    start   = 1'b1;
    data_in = w;
    pat_we  = we_too;
    pat_in  = pin;
    q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    pat_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (junk) begin
        start   = 1'($urandom_range(0, 1));
        pat_we  = 1'($urandom_range(0, 1));
        pat_in  = 4'($urandom);
        data_in = 8'($urandom);
      end
      @(negedge clk);
    end
    start  = 1'b0;
    pat_we = 1'b0;
    @(negedge clk);
    chk("cnt_hold", match_cnt, e.cnt);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset then idle
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_serial", serial_bit, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_cnt", match_cnt, 0);

    // default pattern 1001: matches at bits 4 and 7
    scan(8'b10010010, 1'b0, 1'b0, 4'd0);

    // reprogrammed all-zero pattern: five back-to-back matches
    write_pat(4'b0000);
    scan(8'h00, 1'b0, 1'b0, 4'd0);

    // no match may straddle two words
    write_pat(4'b1001);
    scan(8'b00000100, 1'b0, 1'b0, 4'd0);
    scan(8'b10000000, 1'b0, 1'b0, 4'd0);

    // start and pattern write together: start wins, pattern kept
    scan(8'b10011001, 1'b0, 1'b1, 4'b0000);
    scan(8'b00000000, 1'b0, 1'b0, 4'd0);

    // writes and starts while busy are dropped
    scan(8'b11001001, 1'b1, 1'b0, 4'd0);
    scan(8'b10010010, 1'b0, 1'b0, 4'd0);

    // reset mid-scan at edge E+3
    write_pat(4'b0000);
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'b00001001;
    @(negedge clk);            // after edge E
    start = 1'b0;
    repeat (2) @(negedge clk); // after E+2
    @(posedge clk);            // edge E+3
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", match_cnt, 0);
    chk("abort_pulse", match_pulse, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_pat = 4'b1001;
    repeat (12) @(negedge clk);
    chk("abort_no_done_queue", q.size(), 0);
    scan(8'b10010010, 1'b0, 1'b0, 4'd0);

    // randomized scans with occasional reprogramming and bus noise
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) write_pat(4'($urandom));
      scan(8'($urandom), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), 4'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
